rr_reduce_arbiter: RTL and testbench

- Shares one 4-bit reduction/XOR datapath (OR-reduce, AND-reduce, bitwise XOR) among N ready/valid requesters.
- Arbitration is round-robin. The result is registered into a single-entry output slot with its own ready/valid handshake.
- Sits between the handshake-array producers and the consumer of `out`. The bound RTL monitor checks its handshake and result properties.

---
 rtl/rr_reduce_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 21 ++
 rtl/rr_reduce_arbiter.sv | 80 ++++++++
 tb/tb_rr_reduce_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rr_reduce_pkg.sv
// rr_reduce_pkg: shared types and the round-robin grant search for rr_reduce_arbiter.
package rr_reduce_pkg;
    localparam int WIDTH_D = 4;
    localparam int ID_W_D  = 2;

    typedef enum logic {EMPTY, FULL} slot_state_e;

    typedef struct packed {
        logic              orr;
        logic              andr;
        logic [WIDTH_D-1:0] xr;
        logic [ID_W_D-1:0]  id;
    } result_t;

    // Returns {found, index}; searches last+1, last+2, ... modulo n (n <= 8).
    function automatic logic [3:0] next_grant(input logic [7:0] valid, input logic [2:0] last,
                                              input logic [3:0] n);
        logic [3:0] r;
        logic [3:0] s;
        logic [3:0] idx;
        r = '0;
        for (int k = 1; k <= 8; k++) begin
            s   = {1'b0, last} + k[3:0];
            idx = (s >= n) ? s - n : s;
            if (!r[3] && k[3:0] <= n && valid[idx[2:0]])
                r = {1'b1, idx[2:0]};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant from request valids and the last granted index.
module rr_arbiter
    import rr_reduce_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  last_grant,
    output logic [ID_W-1:0]  grant,
    output logic             grant_valid
);
    logic [3:0] w_r;

    always_comb begin
        w_r = next_grant(8'(req_valid), 3'(last_grant), 4'(N_REQ));
    end

    assign grant       = ID_W'(w_r[2:0]);
    assign grant_valid = w_r[3];
endmodule

// File: rtl/rr_reduce_arbiter.sv
// rr_reduce_arbiter: round-robin sharing of one OR/AND-reduce and XOR datapath among
// ready/valid requesters, with a single registered result slot.
module rr_reduce_arbiter
    import rr_reduce_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int WIDTH = WIDTH_D,
    parameter int ID_W  = ID_W_D,
    parameter int CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RESETN,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_orr,
    output logic                   resp_andr,
    output logic [WIDTH-1:0]       resp_xor,
    output logic [ID_W-1:0]        resp_id,
    output logic [CNT_W-1:0]       served_cnt
);
    slot_state_e      r_state;
    slot_state_e      w_state_nxt;
    result_t          r_res;
    logic [ID_W-1:0]  r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]  w_grant;
    logic             w_gv;
    logic             w_drain;
    logic             w_acc;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req_valid   (req_valid),
        .last_grant  (r_last),
        .grant       (w_grant),
        .grant_valid (w_gv)
    );

    assign w_a = req_a[32'(w_grant)*WIDTH +: WIDTH];
    assign w_b = req_b[32'(w_grant)*WIDTH +: WIDTH];

    // Ready depends only on valids, slot state and resp_ready, never on operand data.
    always_comb begin
        w_drain     = resp_valid && resp_ready;
        w_acc       = RESETN && w_gv && (r_state == EMPTY || w_drain);
        req_ready   = w_acc ? {{(N_REQ-1){1'b0}}, 1'b1} << w_grant : '0;
        w_state_nxt = w_acc ? FULL : w_drain ? EMPTY : r_state;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state <= EMPTY;
            r_res   <= '0;
            r_last  <= ID_W'(N_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_res.orr  <= |w_a;
                r_res.andr <= &w_a;
                r_res.xr   <= w_a ^ w_b;
                r_res.id   <= w_grant;
                r_last     <= w_grant;
                r_cnt      <= r_cnt + 1'b1;
            end
        end
    end

    assign resp_valid = (r_state == FULL);
    assign resp_orr   = r_res.orr;
    assign resp_andr  = r_res.andr;
    assign resp_xor   = r_res.xr;
    assign resp_id    = r_res.id;
    assign served_cnt = r_cnt;
endmodule

// File: tb/tb_rr_reduce_arbiter.sv
// tb_rr_reduce_arbiter: randomized and directed stimulus against a queue-based reference
// model of the round-robin reduce arbiter.
module tb_rr_reduce_arbiter;
    localparam int N  = 3;
    localparam int W  = 4;
    localparam int IW = 2;
    localparam int CW = 8;

    logic            CLK = 0;
    logic            RESETN = 0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a = '0;
    logic [N*W-1:0]  req_b = '0;
    logic            resp_valid;
    logic            resp_ready = 0;
    logic            resp_orr;
    logic            resp_andr;
    logic [W-1:0]    resp_xor;
    logic [IW-1:0]   resp_id;
    logic [CW-1:0]   served_cnt;

    rr_reduce_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW), .CNT_W(CW)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_orr(resp_orr), .resp_andr(resp_andr), .resp_xor(resp_xor),
        .resp_id(resp_id), .served_cnt(served_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int orr;
        int andr;
        int x;
        int id;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    bit           m_full = 0;
    bit           m_rst = 0;
    int           m_last = N - 1;
    int           m_cnt = 0;
    logic [W-1:0] na[N];
    logic [W-1:0] nb[N];

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: advances on each rising edge from the stable inputs.
    always @(posedge CLK) begin : model
        int   g;
        bit   drain;
        exp_t e;
        logic [W-1:0] a;
        if (!RESETN) begin
            m_full = 0;
            m_last = N - 1;
            m_cnt  = 0;
            m_rst  = 1;
            q.delete();
        end else begin
            m_rst = 0;
            drain = m_full && resp_ready;
            g = pick(req_valid, m_last);
            if ((!m_full || drain) && g >= 0) begin
                a      = req_a[g*W +: W];
                e.orr  = (a != 0) ? 1 : 0;
                e.andr = (a == 4'hF) ? 1 : 0;
                e.x    = int'(a ^ req_b[g*W +: W]);
                e.id   = g;
                q.push_back(e);
                m_last = g;
                m_cnt  = (m_cnt + 1) % (1 << CW);
                m_full = 1;
            end else if (drain) begin
                m_full = 0;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires results on handshake.
    always @(negedge CLK) begin : monitor
        int g;
        int er;
        g  = pick(req_valid, m_last);
        er = (RESETN && (!m_full || resp_ready) && g >= 0) ? (1 << g) : 0;
        chk("req_ready", int'(req_ready), er);
        chk("resp_valid", int'(resp_valid), int'(m_full));
        chk("served_cnt", int'(served_cnt), m_cnt);
        if (m_rst)
            chk("reset_fields", int'({resp_orr, resp_andr, resp_xor, resp_id}), 0);
        if (resp_valid && q.size() > 0) begin
            chk("resp_orr", int'(resp_orr), q[0].orr);
            chk("resp_andr", int'(resp_andr), q[0].andr);
            chk("resp_xor", int'(resp_xor), q[0].x);
            chk("resp_id", int'(resp_id), q[0].id);
        end
        if (RESETN && resp_valid && resp_ready) begin
            if (q.size() == 0) chk("unexpected_resp", q.size(), 1);
            else void'(q.pop_front());
        end
    end

    task automatic step(input logic [N-1:0] want, input logic rdy);
        logic [N-1:0] acc;
        @(negedge CLK);
        #1 acc = req_valid & req_ready;
        @(posedge CLK);
        #1;
        resp_ready = rdy;
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || acc[i]) begin
                req_valid[i]     = want[i];
                req_a[i*W +: W]  = na[i];
                req_b[i*W +: W]  = nb[i];
                na[i]            = W'($urandom);
                nb[i]            = W'($urandom);
            end
        end
    endtask

    task automatic drain();
        repeat (4) step('0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            na[i] = W'($urandom);
            nb[i] = W'($urandom);
        end
        req_valid  = '1;
        resp_ready = 1;
        repeat (2) @(posedge CLK);
        #1 RESETN = 1;
        repeat (6) step('1, 1'b1);
        drain();
        na[1] = 4'b1111;
        nb[1] = 4'b0101;
        step(3'b010, 1'b1);
        drain();
        step(3'b001, 1'b0);
        repeat (3) step(3'b110, 1'b0);
        step('0, 1'b1);
        drain();
        repeat (300) step('1, 1'b1);
        drain();
        na[2] = '0;
        nb[2] = '0;
        step(3'b100, 1'b1);
        repeat (3) step('0, 1'b1);
        step(3'b011, 1'b1);
        drain();
        step(3'b001, 1'b0);
        step('0, 1'b0);
        RESETN = 0;
        repeat (2) step('0, 1'b1);
        RESETN = 1;
        repeat (3000) step(N'($urandom), $urandom_range(0, 3) != 0);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
